// File: rtl/fetch_exec_pkg.sv
// Shared types and default widths for the fetch/exec control sequencer.
package fetch_exec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        HALTED = 3'd5
    } seq_state_e;

    localparam int PC_WIDTH_DEF    = 10;
    localparam int CNT_WIDTH_DEF   = 16;
    localparam int MEM_TIMEOUT_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (clear)
            value <= '0;
        else if (inc && value != '1)
            value <= value + WIDTH'(1);
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle FETCH/LOAD/EXEC/MEM sequencer: steps pc, gates decoder write
// enables into commit pulses and runs the data-memory req/ack handshake.
module fetch_exec_sequencer
    import fetch_exec_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_addr,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic                 imem_en,
    output logic                 ir_load,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_reg_write,
    input  logic                 dec_car_write,
    input  logic                 dec_halt,
    input  logic                 jump_en,
    input  logic [PC_WIDTH-1:0]  jump_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 reg_we,
    output logic                 car_we,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    seq_state_e          state, state_next;
    logic [PC_WIDTH-1:0] pc, pc_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                err_q, err_next;
    logic                cnt_clear, instr_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            wait_cnt <= wait_next;
            err_q    <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        wait_next  = wait_cnt;
        err_next   = err_q;
        cnt_clear  = 1'b0;
        instr_inc  = 1'b0;
        imem_en    = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        car_we     = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_next    = start_addr;
                    err_next   = 1'b0;
                    cnt_clear  = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                imem_en    = 1'b1;
                state_next = LOAD;
            end
            LOAD: begin
                ir_load    = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                if (dec_halt) begin
                    instr_inc  = 1'b1;
                    state_next = HALTED;
                end else if (dec_mem_read || dec_mem_write) begin
                    wait_next  = WAIT_W'(1);
                    state_next = MEM;
                end else begin
                    reg_we     = dec_reg_write;
                    car_we     = dec_car_write;
                    pc_next    = jump_en ? jump_target : pc + PC_WIDTH'(1);
                    instr_inc  = 1'b1;
                    state_next = FETCH;
                end
            end
            MEM: begin
                // IR is not reloaded here, so decoder outputs still describe this LW/SW.
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ack) begin
                    reg_we     = dec_mem_read;
                    pc_next    = pc + PC_WIDTH'(1);
                    instr_inc  = 1'b1;
                    state_next = FETCH;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    err_next   = 1'b1;
                    state_next = HALTED;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign busy      = (state == FETCH) || (state == LOAD) || (state == EXEC) || (state == MEM);
    assign done      = (state == HALTED);
    assign err       = err_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (instr_inc),
        .value (instr_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .inc   (busy),
        .value (cycle_count)
    );

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed bench for fetch_exec_sequencer: inputs driven and outputs checked on negedge.
module tb_fetch_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic [9:0]  imem_addr;
    logic        imem_en, ir_load;
    logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_car_write, dec_halt;
    logic        jump_en;
    logic [9:0]  jump_target;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        reg_we, car_we, busy, done, err;
    logic [15:0] instr_count, cycle_count;

    int errors = 0;
    int checks = 0;
    int we_cnt = 0, req_cnt = 0, consec = 0;
    logic prev_we = 1'b0, prev_car = 1'b0, prev_ir = 1'b0;
    int base_we, base_req, cyc0;

    always #5 clk = ~clk;

    fetch_exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr), .imem_en(imem_en), .ir_load(ir_load),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_car_write(dec_car_write),
        .dec_halt(dec_halt), .jump_en(jump_en), .jump_target(jump_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_we(reg_we), .car_we(car_we), .busy(busy), .done(done), .err(err),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    // Strobes are sampled at the edge that consumes them.
    always @(posedge clk) begin
        if (reg_we) we_cnt++;
        if (dmem_req) req_cnt++;
        if ((reg_we && prev_we) || (car_we && prev_car) || (ir_load && prev_ir)) consec++;
        prev_we  = reg_we;
        prev_car = car_we;
        prev_ir  = ir_load;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered at the FETCH negedge; returns at the EXEC negedge.
    task automatic fetch_load(input logic [9:0] addr);
        chk("fetch_en", imem_en, 1);
        chk("fetch_addr", imem_addr, addr);
        @(negedge clk);
        chk("ir_load", ir_load, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0;
        dec_mem_read = 0; dec_mem_write = 0; dec_reg_write = 0; dec_car_write = 0; dec_halt = 0;
        jump_en = 0; jump_target = '0; dmem_ack = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_icnt", instr_count, 0);
        chk("rst_ccnt", cycle_count, 0);
        chk("rst_outs", {imem_en, ir_load, dmem_req, dmem_we, reg_we, car_we, err}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Three ALU instructions then HALT.
        @(negedge clk) begin start = 1; start_addr = 10'h010; end
        @(negedge clk) start = 0;
        chk("busy_fetch", busy, 1);
        base_we = we_cnt;
        dec_reg_write = 1;
        for (int i = 0; i < 3; i++) begin
            fetch_load(10'h010 + 10'(i));
            chk("alu_we", reg_we, 1);
            @(negedge clk);
            chk("alu_we_drop", reg_we, 0);
        end
        dec_reg_write = 0; dec_halt = 1;
        fetch_load(10'h013);
        chk("halt_we", reg_we, 0);
        @(negedge clk);
        dec_halt = 0;
        chk("halt_done", done, 1);
        chk("halt_busy", busy, 0);
        chk("halt_icnt", instr_count, 4);
        chk("halt_ccnt", cycle_count, 12);
        chk("halt_wecnt", we_cnt - base_we, 3);

        // Restart from HALTED; LW acked on third MEM cycle.
        start = 1; start_addr = 10'h020;
        @(negedge clk) start = 0;
        chk("rs_icnt", instr_count, 0);
        chk("rs_ccnt", cycle_count, 0);
        base_we = we_cnt; base_req = req_cnt;
        dec_mem_read = 1;
        fetch_load(10'h020);
        chk("lw_exec_req", dmem_req, 0);
        chk("lw_exec_we", reg_we, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("lw_req", dmem_req, 1);
            chk("lw_dwe", dmem_we, 0);
            chk("lw_noack_we", reg_we, 0);
        end
        @(negedge clk);
        dmem_ack = 1;
        #1;
        chk("lw_ack_req", dmem_req, 1);
        chk("lw_ack_we", reg_we, 1);
        @(negedge clk);
        dmem_ack = 0; dec_mem_read = 0;
        chk("lw_next_pc", imem_addr, 10'h021);
        chk("lw_reqcnt", req_cnt - base_req, 3);
        chk("lw_wecnt", we_cnt - base_we, 1);
        chk("lw_icnt", instr_count, 1);

        // SW acked immediately; jump_en in MEM must be ignored.
        base_we = we_cnt; cyc0 = int'(cycle_count);
        dec_mem_write = 1; jump_en = 1; jump_target = 10'h155;
        fetch_load(10'h021);
        @(negedge clk);
        dmem_ack = 1;
        #1;
        chk("sw_dwe", dmem_we, 1);
        chk("sw_req", dmem_req, 1);
        chk("sw_we", reg_we, 0);
        @(negedge clk);
        dmem_ack = 0; dec_mem_write = 0; jump_en = 0;
        chk("sw_next_pc", imem_addr, 10'h022);
        chk("sw_latency", int'(cycle_count) - cyc0, 4);
        chk("sw_wecnt", we_cnt - base_we, 0);

        // Jump to 0x3FF with a carry commit, then wrap to 0.
        dec_car_write = 1; jump_en = 1; jump_target = 10'h3FF;
        fetch_load(10'h022);
        chk("jmp_car", car_we, 1);
        chk("jmp_reg", reg_we, 0);
        @(negedge clk);
        dec_car_write = 0; jump_en = 0;
        fetch_load(10'h3FF);
        chk("wrap_car", car_we, 0);
        @(negedge clk);
        chk("wrap_pc", imem_addr, 10'h000);

        // LW never acked: timeout after 8 MEM cycles.
        base_we = we_cnt; base_req = req_cnt;
        dec_mem_read = 1;
        fetch_load(10'h000);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("to_req", dmem_req, 1);
        end
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_done", done, 1);
        chk("to_req_off", dmem_req, 0);
        chk("to_reqcnt", req_cnt - base_req, 8);
        chk("to_wecnt", we_cnt - base_we, 0);
        chk("to_icnt", instr_count, 4);
        dec_mem_read = 0;
        start = 1; start_addr = 10'h040;
        @(negedge clk) start = 0;
        chk("clr_err", err, 0);
        chk("clr_icnt", instr_count, 0);
        chk("clr_ccnt", cycle_count, 0);

        // start mid-program is ignored.
        dec_reg_write = 1;
        start = 1; start_addr = 10'h100;
        fetch_load(10'h040);
        chk("mid_we", reg_we, 1);
        @(negedge clk);
        start = 0; dec_reg_write = 0;
        chk("mid_pc", imem_addr, 10'h041);

        // Asynchronous reset while in MEM.
        dec_mem_write = 1;
        fetch_load(10'h041);
        @(negedge clk);
        chk("ar_req_pre", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", dmem_req, 0);
        chk("ar_busy", busy, 0);
        chk("ar_pc", imem_addr, 0);
        dec_mem_write = 0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle_busy", busy, 0);
        chk("ar_idle_done", done, 0);
        chk("ar_idle_pc", imem_addr, 0);

        chk("strobe_consec", consec, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_exec_sequencer.md
Name: fetch_exec_sequencer

Overview:
- Multi-cycle control sequencer for the 9-bit-instruction, 12-register core.
- Steps the program counter, fetches from instruction memory and loads the instruction register feeding the decoder.
- Gates the decoder's register/carry write enables into single-cycle commit pulses and runs the data-memory req/ack handshake for LW/SW.
- Stops on HALT, or on a data-memory timeout.

Parameters:
PC_WIDTH, 10, program counter / instruction address width
CNT_WIDTH, 16, width of instruction and cycle counters
MEM_TIMEOUT, 8, max MEM-state cycles awaiting dmem_ack before error halt (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset
start  in  1  begin execution at start_addr (accepted in IDLE or HALTED only)
start_addr  in  PC_WIDTH  initial PC
imem_addr  out  PC_WIDTH  instruction memory address (= pc)
imem_en  out  1  instruction memory read enable (sync ROM, 1-cycle latency)
ir_load  out  1  latch imem data into instruction register
dec_mem_read  in  1  decoder: LW
dec_mem_write  in  1  decoder: SW
dec_reg_write  in  1  decoder: register write
dec_car_write  in  1  decoder: carry write
dec_halt  in  1  decoder: HALT
jump_en  in  1  branch/jump unit redirect, valid in EXEC
jump_target  in  PC_WIDTH  redirect address
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write qualifier (valid with dmem_req)
dmem_ack  in  1  data memory completion
reg_we  out  1  register file commit strobe
car_we  out  1  carry flag commit strobe
busy  out  1  state not IDLE/HALTED
done  out  1  state HALTED
err  out  1  halted by dmem timeout
instr_count  out  CNT_WIDTH  retired instructions, saturating
cycle_count  out  CNT_WIDTH  busy cycles, saturating

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE, pc 0, counters 0, all outputs 0.
- States: IDLE, FETCH, LOAD, EXEC, MEM, HALTED.
- IDLE: start → pc←start_addr, counters/err cleared, → FETCH.
- FETCH: imem_en=1; → LOAD.
- LOAD: ir_load=1; → EXEC. Decoder outputs are valid during EXEC.
- EXEC:
  - dec_halt → HALTED; instr_count+1; no commit.
  - dec_mem_read or dec_mem_write → MEM; no commit yet.
  - Otherwise: reg_we=dec_reg_write and car_we=dec_car_write for this cycle only; pc←jump_en ? jump_target : pc+1; instr_count+1; → FETCH.
- MEM:
  - dmem_req=1; dmem_we=dec_mem_write. Decoder inputs must stay stable because the IR is not reloaded.
  - Wait counter starts at 1 on entry.
  - dmem_ack while in MEM (may arrive in the first MEM cycle): reg_we=dec_mem_read this cycle; pc←pc+1 (jump_en ignored); instr_count+1; → FETCH.
  - No ack and wait counter == MEM_TIMEOUT → err←1, → HALTED; no commit.
- HALTED: done=1. start restarts exactly as from IDLE.
- start in any other state is ignored. dmem_ack outside MEM is ignored.
- Latency: non-memory instruction 3 cycles. Memory instruction 3+k cycles, where k≥1 is the number of MEM cycles up to and including the ack.
- pc arithmetic is modulo 2^PC_WIDTH; pc+1 from all-ones wraps to 0.
- cycle_count increments every cycle in FETCH/LOAD/EXEC/MEM. Both counters saturate at all-ones.
- Reset asserted mid-operation, including MEM with dmem_req high: all outputs drop immediately and asynchronously; state goes to IDLE.
- reg_we, car_we and ir_load are never high for more than one consecutive cycle.

Decomposition:
- Package fetch_exec_pkg holds:
  - seq_state_e enum: IDLE, FETCH, LOAD, EXEC, MEM, HALTED.
  - Default-width constants.
- Sub-module sat_counter (parameterised width; clear, inc, value) is instanced twice, for instr_count and cycle_count.

Test Plan:
- Reset, start with start_addr=0x010; three ALU instructions with dec_reg_write=1, then HALT → imem_addr 0x010..0x013, 3 single-cycle reg_we pulses, done=1 after 12 busy cycles, instr_count=4, cycle_count=12.
- LW with dmem_ack on the 3rd MEM cycle → dmem_req high exactly 3 cycles, dmem_we=0, one reg_we pulse coincident with ack, next imem_addr=pc+1.
- SW with ack in the first MEM cycle → dmem_we=1, reg_we never asserted, instruction latency 4 cycles.
- jump_en=1, jump_target=0x3FF in EXEC → next fetch at 0x3FF; following non-jump instruction fetches 0x000 (wrap).
- MEM_TIMEOUT=8, never ack → after 8 MEM cycles err=1, done=1, dmem_req=0, no reg_we; a subsequent start clears err and counters.
- start pulsed mid-program → ignored. rst_n low during MEM → dmem_req/busy drop with no clk edge; after release state IDLE, pc=0.
